// File: rtl/cb_routing_param.sv
`default_nettype none
// ============================================================================
// Module   : cb_routing_param
// Purpose  : Parametrised connection block. A serially loaded, double-buffered
//            frame routes the channel onto CLB input pins and merges the CLB
//            output onto the side channel.
// Revision : 1.0 - initial release
// ============================================================================
module cb_routing_param #(
    parameter int W     = 4,
    parameter int K     = 4,
    parameter int SEL_W = $clog2(2*W)
) (
    input  logic         prog_clk,
    input  logic         rst,
    input  logic         prog_en,
    input  logic         prog_in,
    input  logic         prog_commit,
    output logic         prog_out,
    output logic         cfg_valid,
    output logic         cfg_err,
    input  logic [W-1:0] chan_in,
    input  logic [W-1:0] chan_sb_out,
    input  logic [W-1:0] side_in,
    input  logic [W-1:0] sb_side_out,
    input  logic         clb_out,
    output logic [K-1:0] clb_in,
    output logic [W-1:0] side_out,
    output logic [W-1:0] sb_side_in
);

    localparam int CFG_LEN = K*SEL_W + 2*W + 1;
    localparam int CNT_W   = $clog2(CFG_LEN + 2);
    localparam int MUX_N   = 2**SEL_W;

    localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(CFG_LEN);
    localparam logic [CNT_W-1:0] c_CNT_SAT  = CNT_W'(CFG_LEN + 1);

    logic [CFG_LEN-1:0] r_shadow;
    // The parity bit is only needed at commit time, so it is not kept active.
    logic [CFG_LEN-1:1] r_active;
    logic [CNT_W-1:0]   r_count;
    logic               r_cfg_valid;
    logic               r_cfg_err;

    logic               w_accept;
    logic [2*W-1:0]     w_chan_vec;
    logic [MUX_N-1:0]   w_mux_vec;

    assign w_accept = (r_count == c_CNT_FULL) && !(^r_shadow) && !prog_en;

    always_ff @(posedge prog_clk or negedge rst) begin
        if (!rst) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_count     <= '0;
            r_cfg_valid <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            if (prog_en) begin
                r_shadow <= {prog_in, r_shadow[CFG_LEN-1:1]};
            end
            if (prog_commit) begin
                // A shift coinciding with the commit is the first bit of the next frame.
                r_count <= prog_en ? CNT_W'(1) : '0;
                if (w_accept) begin
                    r_active    <= r_shadow[CFG_LEN-1:1];
                    r_cfg_valid <= 1'b1;
                    r_cfg_err   <= 1'b0;
                end else begin
                    r_cfg_err   <= 1'b1;
                end
            end else if (prog_en && (r_count != c_CNT_SAT)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign prog_out  = r_shadow[0];
    assign cfg_valid = r_cfg_valid;
    assign cfg_err   = r_cfg_err;

    // Unused select codes above 2W read the zero padding.
    always_comb begin
        w_mux_vec            = '0;
        w_mux_vec[2*W-1:0]   = w_chan_vec;
    end

    for (genvar j = 0; j < W; j++) begin : g_chan
        assign w_chan_vec[2*j]   = chan_sb_out[j];
        assign w_chan_vec[2*j+1] = chan_in[j];
        assign side_out[j]   = (r_cfg_valid && r_active[2*j+1]) ? clb_out : sb_side_out[j];
        assign sb_side_in[j] = (r_cfg_valid && r_active[2*j+2]) ? clb_out : side_in[j];
    end

    for (genvar k = 0; k < K; k++) begin : g_clb
        logic [SEL_W-1:0] w_sel;
        assign w_sel     = r_active[2*W+1+k*SEL_W +: SEL_W];
        assign clb_in[k] = r_cfg_valid & w_mux_vec[w_sel];
    end

endmodule
`default_nettype wire

// File: tb/tb_cb_routing_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_cb_routing_param
// Purpose  : Scoreboard bench for cb_routing_param with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cb_routing_param;

    localparam int W = 4;
    localparam int K = 4;

    // Frame A: clb_in[0] sel 5, side_out[1] sel; Frame B: clb_in[3] sel 6, sb_side_in[2] sel.
    localparam logic [31:0] c_FRAME_A = 32'h000A09;
    localparam logic [31:0] c_FRAME_B = 32'h180041;
    // Even-parity frame with side_out[0] also selected; shifted one place for the short test.
    localparam logic [31:0] c_FRAME_E = 32'h180042;

    logic         prog_clk = 1'b0;
    logic         rst;
    logic         prog_en;
    logic         prog_in;
    logic         prog_commit;
    logic         prog_out;
    logic         cfg_valid;
    logic         cfg_err;
    logic [W-1:0] chan_in;
    logic [W-1:0] chan_sb_out;
    logic [W-1:0] side_in;
    logic [W-1:0] sb_side_out;
    logic         clb_out;
    logic [K-1:0] clb_in;
    logic [W-1:0] side_out;
    logic [W-1:0] sb_side_in;

    cb_routing_param #(.W(W), .K(K)) dut (
        .prog_clk    (prog_clk),
        .rst         (rst),
        .prog_en     (prog_en),
        .prog_in     (prog_in),
        .prog_commit (prog_commit),
        .prog_out    (prog_out),
        .cfg_valid   (cfg_valid),
        .cfg_err     (cfg_err),
        .chan_in     (chan_in),
        .chan_sb_out (chan_sb_out),
        .side_in     (side_in),
        .sb_side_out (sb_side_out),
        .clb_out     (clb_out),
        .clb_in      (clb_in),
        .side_out    (side_out),
        .sb_side_in  (sb_side_in)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        string        name;
        logic [K-1:0] clb;
        logic [W-1:0] so;
        logic [W-1:0] ssi;
        logic         v;
        logic         e;
        logic         po;
        bit           chk_po;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always @(negedge prog_clk) begin
        exp_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            vectors++;
            if (clb_in !== x.clb || side_out !== x.so || sb_side_in !== x.ssi ||
                cfg_valid !== x.v || cfg_err !== x.e || (x.chk_po && prog_out !== x.po)) begin
                miscompares++;
                $display("FAIL %s: got clb_in=%b side_out=%b sb_side_in=%b valid=%b err=%b prog_out=%b, required clb_in=%b side_out=%b sb_side_in=%b valid=%b err=%b prog_out=%b(%0s)",
                         x.name, clb_in, side_out, sb_side_in, cfg_valid, cfg_err, prog_out,
                         x.clb, x.so, x.ssi, x.v, x.e, x.po, x.chk_po ? "checked" : "ignored");
            end
        end
    end

    task automatic expect_out(input string name, input logic [K-1:0] clb,
                              input logic [W-1:0] so, input logic [W-1:0] ssi,
                              input logic v, input logic e, input logic po, input bit chk_po);
        exp_t x;
        x.name = name; x.clb = clb; x.so = so; x.ssi = ssi;
        x.v = v; x.e = e; x.po = po; x.chk_po = chk_po;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic set_io(input logic [W-1:0] ci, input logic [W-1:0] csb,
                          input logic [W-1:0] si, input logic [W-1:0] sbo, input logic co);
        chan_in = ci; chan_sb_out = csb; side_in = si; sb_side_out = sbo; clb_out = co;
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n);
        prog_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            prog_in = bits[i];
            tick();
        end
        prog_en = 1'b0;
        prog_in = 1'b0;
    endtask

    task automatic commit();
        prog_commit = 1'b1;
        tick();
        prog_commit = 1'b0;
    endtask

    // Frame A and frame B input patterns with hand-computed routing results.
    task automatic check_a1(input string name, input logic e);
        set_io(4'b0100, 4'b0000, 4'b1010, 4'b0000, 1'b1);
        expect_out(name, 4'b0001, 4'b0010, 4'b1010, 1'b1, e, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_a2(input string name, input logic e);
        set_io(4'b1011, 4'b0001, 4'b0101, 4'b1111, 1'b0);
        expect_out(name, 4'b1110, 4'b1101, 4'b0101, 1'b1, e, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_b1(input string name, input logic e);
        set_io(4'b1111, 4'b1000, 4'b0000, 4'b0101, 1'b1);
        expect_out(name, 4'b1000, 4'b0101, 4'b0100, 1'b1, e, 1'b0, 1'b0);
        tick();
    endtask

    task automatic check_b2(input string name, input logic e);
        set_io(4'b0000, 4'b0001, 4'b1111, 4'b0101, 1'b0);
        expect_out(name, 4'b0111, 4'b0101, 4'b1011, 1'b1, e, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        rst = 1'b0; prog_en = 1'b0; prog_in = 1'b0; prog_commit = 1'b0;
        set_io(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        tick();

        for (int i = 0; i < 2; i++) begin
            set_io(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
            expect_out("reset", '0, sb_side_out, side_in, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        rst = 1'b1;
        tick();

        shift_bits(c_FRAME_A, 21);
        set_io(4'b0011, 4'b1100, 4'b0110, 4'b1001, 1'b1);
        expect_out("chain_a_unconfigured", '0, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        commit();
        check_a1("good_frame_a1", 1'b0);
        check_a2("good_frame_a2", 1'b0);
        commit();
        check_a1("back_to_back_commit", 1'b1);

        shift_bits(c_FRAME_E >> 1, 20);
        commit();
        check_a1("short_frame", 1'b1);

        shift_bits(c_FRAME_A ^ 32'h20, 21);
        commit();
        check_a2("bad_parity", 1'b1);
        shift_bits(c_FRAME_B, 21);
        commit();
        check_b1("recovery_b1", 1'b0);
        check_b2("recovery_b2", 1'b0);

        // Overlong: bits 0,1,1,0... shifted 22 times over frame B in the shadow.
        shift_bits(32'h6, 20);
        set_io(4'b1111, 4'b1000, 4'b0000, 4'b0101, 1'b1);
        expect_out("chain_20_shifts", 4'b1000, 4'b0101, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        shift_bits(32'h0, 1);
        expect_out("chain_first_bit_out", 4'b1000, 4'b0101, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        shift_bits(32'h0, 1);
        expect_out("chain_second_bit_out", 4'b1000, 4'b0101, 4'b0100, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        commit();
        check_b1("overlong_rejected", 1'b1);

        prog_en = 1'b1; prog_in = c_FRAME_A[0]; prog_commit = 1'b1;
        tick();
        prog_en = 1'b0; prog_in = 1'b0; prog_commit = 1'b0;
        check_b1("commit_with_shift_rejected", 1'b1);
        shift_bits(c_FRAME_A >> 1, 20);
        commit();
        check_a1("count_restarts_at_one", 1'b0);

        shift_bits(c_FRAME_B, 10);
        rst = 1'b0;
        set_io(4'b1010, 4'b0110, 4'b1100, 4'b0011, 1'b1);
        expect_out("reset_mid_shift", '0, 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        shift_bits(c_FRAME_B, 21);
        commit();
        check_b1("after_reset_frame_b", 1'b0);

        tick();
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
